// File: rtl/alu_seq.sv
// Sequential Hack-style ALU with valid/ready handshake, carry/overflow flags,
// and multi-cycle shift-add multiply and one-bit-per-cycle logical shifts.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);
  localparam int SHW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_HACK = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic             no_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] x1, x2, y1, y2, sum, hack_r, acc_step, fin_raw, fin;
  logic             carry, hack_cy, hack_ov, fin_no, fin_cy, fin_ov;
  logic [1:0]       op_eff;
  logic [SHW-1:0]   amt;

  assign in_ready = (state == S_IDLE);

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    x1 = zx ? '0 : x;
    x2 = nx ? ~x1 : x1;
    y1 = zy ? '0 : y;
    y2 = ny ? ~y1 : y1;
    {carry, sum} = {1'b0, x2} + {1'b0, y2};
    hack_r  = f ? sum : (x2 & y2);
    hack_cy = f & carry;
    hack_ov = f & (x2[WIDTH-1] == y2[WIDTH-1]) & (sum[WIDTH-1] != x2[WIDTH-1]);
    op_eff  = (op == OP_MUL && !MUL_EN) ? OP_HACK : op;
    amt     = y2[SHW-1:0];

    if (op_q == OP_MUL)      acc_step = mplier[0] ? acc + mcand : acc;
    else if (op_q == OP_SHL) acc_step = acc << 1;
    else                     acc_step = acc >> 1;

    // In IDLE the result comes straight from the inputs (HACK or zero shift).
    if (state == S_IDLE) begin
      fin_raw = (op_eff == OP_HACK) ? hack_r : x2;
      fin_no  = no;
      fin_cy  = (op_eff == OP_HACK) & hack_cy;
      fin_ov  = (op_eff == OP_HACK) & hack_ov;
    end else begin
      fin_raw = acc_step;
      fin_no  = no_q;
      fin_cy  = 1'b0;
      fin_ov  = 1'b0;
    end
    fin = fin_no ? ~fin_raw : fin_raw;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_HACK;
      no_q      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      cy        <= 1'b0;
      ov        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q   <= op_eff;
            no_q   <= no;
            mcand  <= x2;
            mplier <= y2;
            if (op_eff == OP_HACK || (op_eff != OP_MUL && amt == '0)) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              out       <= fin;
              zr        <= (fin == '0);
              ng        <= fin[WIDTH-1];
              cy        <= fin_cy;
              ov        <= fin_ov;
            end else if (op_eff == OP_MUL) begin
              state <= S_BUSY;
              acc   <= '0;
              cnt   <= CW'(WIDTH);
            end else begin
              state <= S_BUSY;
              acc   <= x2;
              cnt   <= CW'(amt);
            end
          end
        end
        S_BUSY: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out       <= fin;
            zr        <= (fin == '0);
            ng        <= fin[WIDTH-1];
            cy        <= fin_cy;
            ov        <= fin_ov;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
